// File: rtl/ps2_led_cmd_sender_if.sv
// rtl/ps2_led_cmd_sender_if.sv - request/controller bus for the PS/2 LED command sender
//
// Signals:
//   led_mask[2:0]                 requested LEDs (bit0 Scroll, bit1 Num, bit2 Caps)
//   update_req                    one-cycle request to write led_mask to the keyboard
//   command_was_sent              controller reports byte transmitted
//   error_communication_timed_out controller reports transmit failure
//   received_data[7:0]            byte received from the keyboard
//   received_data_en              one-cycle valid for received_data
//   the_command[7:0]              byte handed to the controller
//   send_command                  transmit request to the controller
//   busy                          sequence in progress
//   done                          one-cycle pulse, sequence acknowledged
//   error                         one-cycle pulse, sequence failed
// Modports: master drives requests and controller responses, slave is the sender.
interface ps2_led_cmd_sender_if;
  logic [2:0] led_mask;
  logic       update_req;
  logic       command_was_sent;
  logic       error_communication_timed_out;
  logic [7:0] received_data;
  logic       received_data_en;
  logic [7:0] the_command;
  logic       send_command;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output led_mask, update_req, command_was_sent, error_communication_timed_out,
           received_data, received_data_en,
    input  the_command, send_command, busy, done, error
  );

  modport slave (
    input  led_mask, update_req, command_was_sent, error_communication_timed_out,
           received_data, received_data_en,
    output the_command, send_command, busy, done, error
  );
endinterface

// File: rtl/ps2_led_cmd_sender.sv
// rtl/ps2_led_cmd_sender.sv - writes the keyboard LED mask via the ED/mask/FA exchange
//
// Ports:
//   CLOCK_50  sole clock, rising edge
//   reset     asynchronous active-high reset
//   bus       ps2_led_cmd_sender_if.slave (request side and PS/2 controller side)
// Parameters:
//   ACK_TIMEOUT  clock cycles allowed for each keyboard response
//   MAX_RETRY    resends allowed per byte after an FE reply
// Build option:
//   PS2_LED_RETRY_EN  when defined, an FE reply resends the byte (up to MAX_RETRY
//                     times); otherwise an FE reply fails the sequence.
module ps2_led_cmd_sender #(
  parameter int ACK_TIMEOUT = 1000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  ps2_led_cmd_sender_if.slave  bus
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_ED,
    S_ACK_ED,
    S_TX_MASK,
    S_ACK_MASK
  } state_t;

  state_t        r_state;
  logic [2:0]    r_mask;
  logic [2:0]    r_shadow;
  logic          r_pending;
  logic [CW-1:0] r_ack_cnt;
  logic [7:0]    r_the_command;
  logic          r_send;
  logic          r_busy;
  logic          r_done;
  logic          r_error;

  logic          w_rx_fa;
  logic          w_rx_fe;
  logic          w_ack_expired;

  assign w_rx_fa       = bus.received_data_en && (bus.received_data == 8'hFA);
  assign w_rx_fe       = bus.received_data_en && (bus.received_data == 8'hFE);
  assign w_ack_expired = (r_ack_cnt == CW'(ACK_TIMEOUT - 1));

`ifdef PS2_LED_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] r_retry_cnt;
`endif

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_mask        <= 3'b000;
      r_shadow      <= 3'b000;
      r_pending     <= 1'b0;
      r_ack_cnt     <= '0;
      r_the_command <= 8'h00;
      r_send        <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
`ifdef PS2_LED_RETRY_EN
      r_retry_cnt   <= '0;
`endif
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;

      // Any request while a sequence is running (including the completing
      // cycle) is parked; the newest mask wins.
      if (r_state != S_IDLE && bus.update_req) begin
        r_pending <= 1'b1;
        r_shadow  <= bus.led_mask;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.update_req || r_pending) begin
            r_mask        <= bus.update_req ? bus.led_mask : r_shadow;
            r_pending     <= 1'b0;
            r_the_command <= 8'hED;
            r_send        <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= S_TX_ED;
`ifdef PS2_LED_RETRY_EN
            r_retry_cnt   <= '0;
`endif
          end
        end

        S_TX_ED, S_TX_MASK: begin
          // A controller failure outranks a simultaneous sent indication.
          if (bus.error_communication_timed_out) begin
            r_send  <= 1'b0;
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (bus.command_was_sent) begin
            r_send    <= 1'b0;
            r_ack_cnt <= '0;
            r_state   <= (r_state == S_TX_ED) ? S_ACK_ED : S_ACK_MASK;
          end
        end

        S_ACK_ED, S_ACK_MASK: begin
          if (w_rx_fa) begin
`ifdef PS2_LED_RETRY_EN
            r_retry_cnt <= '0;
`endif
            if (r_state == S_ACK_ED) begin
              r_the_command <= {5'b00000, r_mask};
              r_send        <= 1'b1;
              r_state       <= S_TX_MASK;
            end else begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else if (w_rx_fe) begin
`ifdef PS2_LED_RETRY_EN
            if (r_retry_cnt == RW'(MAX_RETRY)) begin
              r_error <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              // the_command still holds the byte being answered.
              r_retry_cnt <= r_retry_cnt + 1'b1;
              r_send      <= 1'b1;
              r_state     <= (r_state == S_ACK_ED) ? S_TX_ED : S_TX_MASK;
            end
`else
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
`endif
          end else if (w_ack_expired) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            // Unrelated bytes (scan codes, F0) fall through here and do not
            // restart the response window.
            r_ack_cnt <= r_ack_cnt + 1'b1;
          end
        end

        default: begin
          r_send  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.the_command  = r_the_command;
  assign bus.send_command = r_send;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.error        = r_error;

endmodule

// File: tb/tb_ps2_led_cmd_sender.sv
// tb/tb_ps2_led_cmd_sender.sv - directed self-checking bench for ps2_led_cmd_sender
module tb_ps2_led_cmd_sender;

  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ps2_led_cmd_sender_if u_if ();

  ps2_led_cmd_sender #(
    .ACK_TIMEOUT (TO),
    .MAX_RETRY   (3)
  ) u_dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (u_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int   done_cnt  = 0;
  int   both_cnt  = 0;
  int   tx_cnt    = 0;
  logic prev_send = 1'b0;

  always @(negedge clk) begin
    if (u_if.done) done_cnt <= done_cnt + 1;
    if (u_if.done && u_if.error) both_cnt <= both_cnt + 1;
    if (u_if.send_command && !prev_send) tx_cnt <= tx_cnt + 1;
    prev_send <= u_if.send_command;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_upd(input logic [2:0] m);
    u_if.led_mask   = m;
    u_if.update_req = 1'b1;
    tick();
    u_if.update_req = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    u_if.received_data    = b;
    u_if.received_data_en = 1'b1;
    tick();
    u_if.received_data_en = 1'b0;
  endtask

  // Waits for a transmit request, checks the byte and that it is held, then
  // acknowledges it and checks that the request drops on that edge.
  task automatic expect_tx(input string tag, input logic [7:0] exp);
    int n = 0;
    while (u_if.send_command !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check_eq({tag, "_req"}, 32'(u_if.send_command), 32'd1);
    check_eq({tag, "_byte"}, 32'(u_if.the_command), 32'(exp));
    tick();
    check_eq({tag, "_hold"}, 32'(u_if.send_command), 32'd1);
    u_if.command_was_sent = 1'b1;
    tick();
    u_if.command_was_sent = 1'b0;
    check_eq({tag, "_drop"}, 32'(u_if.send_command), 32'd0);
  endtask

  task automatic expect_done(input string tag);
    int n = 0;
    while (u_if.done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check_eq({tag, "_done"}, 32'(u_if.done), 32'd1);
    tick();
    check_eq({tag, "_done_pulse"}, 32'(u_if.done), 32'd0);
  endtask

  initial begin
    int k;
    int tx_base;
    int exp_done;
    logic seen;

    u_if.led_mask                      = 3'b000;
    u_if.update_req                    = 1'b0;
    u_if.command_was_sent              = 1'b0;
    u_if.error_communication_timed_out = 1'b0;
    u_if.received_data                 = 8'h00;
    u_if.received_data_en              = 1'b0;

    // Reset state
    repeat (3) tick();
    check_eq("rst_cmd",  32'(u_if.the_command),  32'h00);
    check_eq("rst_send", 32'(u_if.send_command), 32'd0);
    check_eq("rst_busy", 32'(u_if.busy),         32'd0);
    check_eq("rst_done", 32'(u_if.done),         32'd0);
    check_eq("rst_err",  32'(u_if.error),        32'd0);
    rst = 1'b0;
    tick();

    // Basic sequence, mask 101
    pulse_upd(3'b101);
    check_eq("basic_busy", 32'(u_if.busy), 32'd1);
    expect_tx("basic_ed", 8'hED);
    send_rx(8'hFA);
    expect_tx("basic_mask", 8'h05);
    send_rx(8'hFA);
    expect_done("basic");
    check_eq("basic_idle", 32'(u_if.busy), 32'd0);

    // Unrelated bytes during ACK_ED are ignored
    pulse_upd(3'b010);
    expect_tx("ign_ed", 8'hED);
    send_rx(8'h1C);
    send_rx(8'hF0);
    send_rx(8'h1C);
    check_eq("ign_still_busy", 32'(u_if.busy), 32'd1);
    check_eq("ign_no_send", 32'(u_if.send_command), 32'd0);
    send_rx(8'hFA);
    expect_tx("ign_mask", 8'h02);
    send_rx(8'hFA);
    expect_done("ign");

    // No response: error exactly TO cycles after ACK_ED entry
    pulse_upd(3'b001);
    expect_tx("to_ed", 8'hED);
    k = 0;
    while (u_if.error !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    check_eq("to_cycles", 32'(k), 32'(TO));
    check_eq("to_send", 32'(u_if.send_command), 32'd0);
    check_eq("to_busy", 32'(u_if.busy), 32'd0);
    tick();

    // Controller transmit failure
    pulse_upd(3'b001);
    u_if.error_communication_timed_out = 1'b1;
    tick();
    u_if.error_communication_timed_out = 1'b0;
    check_eq("txerr_err",  32'(u_if.error),        32'd1);
    check_eq("txerr_send", 32'(u_if.send_command), 32'd0);
    check_eq("txerr_busy", 32'(u_if.busy),         32'd0);
    tick();

    // FE on the mask byte
    pulse_upd(3'b011);
    expect_tx("fe_ed", 8'hED);
    send_rx(8'hFA);
    tx_base = tx_cnt;
    expect_tx("fe_mask1", 8'h03);
    send_rx(8'hFE);
`ifdef PS2_LED_RETRY_EN
    check_eq("fe_retry_noerr", 32'(u_if.error), 32'd0);
    expect_tx("fe_mask2", 8'h03);
    send_rx(8'hFE);
    expect_tx("fe_mask3", 8'h03);
    send_rx(8'hFA);
    expect_done("fe");
    check_eq("fe_mask_tx_count", 32'(tx_cnt - tx_base), 32'd3);
`else
    check_eq("fe_err",  32'(u_if.error), 32'd1);
    check_eq("fe_busy", 32'(u_if.busy),  32'd0);
    tick();
    check_eq("fe_mask_tx_count", 32'(tx_cnt - tx_base), 32'd1);
`endif

    // Request while busy is replayed with the newest mask
    pulse_upd(3'b001);
    expect_tx("pend1_ed", 8'hED);
    pulse_upd(3'b110);
    send_rx(8'hFA);
    expect_tx("pend1_mask", 8'h01);
    send_rx(8'hFA);
    expect_done("pend1");
    expect_tx("pend2_ed", 8'hED);
    send_rx(8'hFA);
    expect_tx("pend2_mask", 8'h06);
    send_rx(8'hFA);
    expect_done("pend2");
    repeat (3) tick();
    check_eq("pend_cleared", 32'(u_if.busy), 32'd0);

    // Request coincident with completion is not lost
    pulse_upd(3'b100);
    expect_tx("coin1_ed", 8'hED);
    send_rx(8'hFA);
    expect_tx("coin1_mask", 8'h04);
    u_if.received_data    = 8'hFA;
    u_if.received_data_en = 1'b1;
    u_if.led_mask         = 3'b011;
    u_if.update_req       = 1'b1;
    tick();
    u_if.received_data_en = 1'b0;
    u_if.update_req       = 1'b0;
    expect_done("coin1");
    expect_tx("coin2_ed", 8'hED);
    send_rx(8'hFA);
    expect_tx("coin2_mask", 8'h03);
    send_rx(8'hFA);
    expect_done("coin2");

    // Reset during TX_MASK with a request pending
    pulse_upd(3'b111);
    expect_tx("rmid_ed", 8'hED);
    pulse_upd(3'b010);
    send_rx(8'hFA);
    check_eq("rmid_tx_mask", 32'(u_if.send_command), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("rmid_send_async", 32'(u_if.send_command), 32'd0);
    check_eq("rmid_cmd", 32'(u_if.the_command), 32'h00);
    check_eq("rmid_busy", 32'(u_if.busy), 32'd0);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (u_if.send_command || u_if.busy) seen = 1'b1;
    end
    check_eq("rmid_no_restart", 32'(seen), 32'd0);

`ifdef PS2_LED_RETRY_EN
    exp_done = 7;
`else
    exp_done = 6;
`endif
    check_eq("done_total", 32'(done_cnt), 32'(exp_done));
    check_eq("done_err_overlap", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
